// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS-subset core: sequences the shared memory, ALU and holding registers.
// Optional performance counters (cycle_cnt_o, instr_cnt_o) are enabled with `define MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl #(
    parameter int ST_W     = 4,
    parameter int ALU_OP_W = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [5:0]          instr_op_i,
    input  logic                mem_ready_i,
    output logic                pc_write_o,
    output logic                pc_write_cond_o,
    output logic                branch_type_o,
    output logic [1:0]          pc_source_o,
    output logic                iord_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                ir_write_o,
    output logic                reg_write_o,
    output logic                reg_dst_o,
    output logic [1:0]          mem_to_reg_o,
    output logic                alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                illegal_o,
`ifdef MULTICYCLE_CTRL_PERF_EN
    output logic [31:0]         cycle_cnt_o,
    output logic [31:0]         instr_cnt_o,
`endif
    output logic [ST_W-1:0]     state_o
);

    typedef enum logic [ST_W-1:0] {
        FETCH    = ST_W'(0),
        DECODE   = ST_W'(1),
        EXEC_R   = ST_W'(2),
        WB_ALU   = ST_W'(3),
        EXEC_I   = ST_W'(4),
        MEM_ADDR = ST_W'(5),
        MEM_RD   = ST_W'(6),
        MEM_WB   = ST_W'(7),
        MEM_WR   = ST_W'(8),
        BRANCH   = ST_W'(9),
        JUMP     = ST_W'(10),
        LI_WB    = ST_W'(11)
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_LI    = 6'b001111;

    state_e state_reg, state_next;
    logic   reg_dst_reg, reg_dst_next;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= FETCH;
            reg_dst_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            reg_dst_reg <= reg_dst_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        reg_dst_next    = reg_dst_reg;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        branch_type_o   = 1'b0;
        pc_source_o     = 2'b00;
        iord_o          = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        reg_write_o     = 1'b0;
        reg_dst_o       = 1'b0;
        mem_to_reg_o    = 2'b00;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = 2'b00;
        alu_op_o        = '0;
        illegal_o       = 1'b0;
        // Outputs stay quiet for the whole reset pulse even though the state already reads FETCH.
        if (!rst_i) begin
            unique case (state_reg)
                FETCH: begin
                    mem_read_o = 1'b1;
                    if (mem_ready_i) begin
                        ir_write_o  = 1'b1;
                        pc_write_o  = 1'b1;
                        alu_src_b_o = 2'b01;
                        state_next  = DECODE;
                    end
                end
                DECODE: begin
                    alu_src_b_o = 2'b11;
                    unique case (instr_op_i)
                        OP_RTYPE:       state_next = EXEC_R;
                        OP_ADDI:        state_next = EXEC_I;
                        OP_LW, OP_SW:   state_next = MEM_ADDR;
                        OP_BEQ, OP_BNE: state_next = BRANCH;
                        OP_J:           state_next = JUMP;
                        OP_LI:          state_next = LI_WB;
                        default: begin
                            illegal_o  = 1'b1;
                            state_next = FETCH;
                        end
                    endcase
                end
                EXEC_R: begin
                    alu_src_a_o  = 1'b1;
                    alu_op_o     = ALU_OP_W'(2);
                    reg_dst_next = 1'b1;
                    state_next   = WB_ALU;
                end
                EXEC_I: begin
                    alu_src_a_o  = 1'b1;
                    alu_src_b_o  = 2'b10;
                    reg_dst_next = 1'b0;
                    state_next   = WB_ALU;
                end
                WB_ALU: begin
                    reg_write_o = 1'b1;
                    reg_dst_o   = reg_dst_reg;
                    state_next  = FETCH;
                end
                MEM_ADDR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                    state_next  = (instr_op_i == OP_SW) ? MEM_WR : MEM_RD;
                end
                MEM_RD: begin
                    mem_read_o = 1'b1;
                    iord_o     = 1'b1;
                    if (mem_ready_i) state_next = MEM_WB;
                end
                MEM_WB: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 2'b01;
                    state_next   = FETCH;
                end
                MEM_WR: begin
                    mem_write_o = 1'b1;
                    iord_o      = 1'b1;
                    if (mem_ready_i) state_next = FETCH;
                end
                BRANCH: begin
                    alu_src_a_o     = 1'b1;
                    alu_op_o        = ALU_OP_W'(1);
                    pc_write_cond_o = 1'b1;
                    pc_source_o     = 2'b01;
                    branch_type_o   = instr_op_i[0];
                    state_next      = FETCH;
                end
                JUMP: begin
                    pc_write_o  = 1'b1;
                    pc_source_o = 2'b10;
                    state_next  = FETCH;
                end
                LI_WB: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 2'b10;
                    state_next   = FETCH;
                end
                default: state_next = FETCH;
            endcase
        end
    end

    assign state_o = state_reg;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt_reg, instr_cnt_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle_cnt_reg <= '0;
            instr_cnt_reg <= '0;
        end else begin
            cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
            if (state_reg != FETCH && state_next == FETCH)
                instr_cnt_reg <= instr_cnt_reg + 32'd1;
        end
    end

    assign cycle_cnt_o = cycle_cnt_reg;
    assign instr_cnt_o = instr_cnt_reg;
`endif

endmodule
